// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the decode/redirect side.
// master = fetch stage, slave = memory + downstream pipeline.
interface cpu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [47:0] imem_rdata;
    logic        stall_2a;
    logic        kill_4a;
    logic [31:0] target_4a;
    logic [47:0] instruction_1a;
    logic [31:0] pc_1a;

    modport master (
        output imem_req, imem_addr, instruction_1a, pc_1a,
        input  imem_ack, imem_rdata, stall_2a, kill_4a, target_4a
    );

    modport slave (
        input  imem_req, imem_addr, instruction_1a, pc_1a,
        output imem_ack, imem_rdata, stall_2a, kill_4a, target_4a
    );
endinterface

// File: rtl/cpu_fetch.sv
// Stage-1 fetch: one-outstanding imem requests into a DEPTH-entry prefetch FIFO feeding decode; optional FETCH_BYPASS_EN.
// Latency: ack in cycle N reaches decode at N+1 via bypass, N+2 through the FIFO (default build).
// Backpressure: stall_2a holds the output register; requests stop once the FIFO would be full.
module cpu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          INSN_BYTES = 6
) (
    input  logic        clk,
    input  logic        rst_b,
    cpu_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [47:0] insn;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   redir_pc_q, redir_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        out_q, out_d;
    entry_t        fifo_q [DEPTH];
    entry_t        push_dat;
    logic          ack, push, pop, byp;

    assign bus.imem_req       = (state_q != IDLE);
    assign bus.imem_addr      = fpc_q;
    assign bus.instruction_1a = out_q.insn;
    assign bus.pc_1a          = out_q.pc;
    assign push_dat           = '{pc: fpc_q, insn: bus.imem_rdata};

    always_comb begin
        ack = bus.imem_req && bus.imem_ack;
        pop = !bus.kill_4a && !bus.stall_2a && (count_q != '0);
`ifdef FETCH_BYPASS_EN
        byp = !bus.kill_4a && !bus.stall_2a && (count_q == '0) && (state_q == REQ) && ack;
`else
        byp = 1'b0;
`endif
        // Responses in DROP are wrong-path and never enter the FIFO.
        push = (state_q == REQ) && ack && !bus.kill_4a && !byp;

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.kill_4a) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            IDLE: if (count_d < DEPTH_C) state_d = REQ;
            REQ: begin
                if (ack) begin
                    fpc_d   = fpc_q + 32'(INSN_BYTES);
                    state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack) begin
                    fpc_d   = redir_pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        // A request already on the bus cannot be withdrawn, so an unacked kill parks in DROP.
        if (bus.kill_4a) begin
            if (state_q == IDLE || ack) begin
                fpc_d   = bus.target_4a;
                state_d = REQ;
            end else begin
                redir_pc_d = bus.target_4a;
                state_d    = DROP;
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (bus.kill_4a) begin
            out_d = '{pc: bus.target_4a, insn: 48'h0};
        end else if (!bus.stall_2a) begin
            if (count_q != '0)
                out_d = fifo_q[rd_ptr_q];
            else if (byp)
                out_d = push_dat;
            else
                out_d = '{pc: (state_q == DROP) ? redir_pc_q : fpc_q, insn: 48'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= REQ;
            fpc_q      <= RESET_PC;
            redir_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_q      <= '{pc: RESET_PC, insn: 48'h0};
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            redir_pc_q <= redir_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_dat;
    end
endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: granted memory responses push expected {pc,insn}; a monitor checks decode output.
module tb_cpu_fetch;
    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    cpu_fetch_if bus();
    cpu_fetch dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int grant_total = 0;
    int ack_total   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ack_log[$];
    logic        upd = 1'b0;
    logic [31:0] e_pc;

    function automatic logic [47:0] mdata(input logic [31:0] a);
        return {16'hD5A0 ^ a[15:0], a};
    endfunction

    // Memory: zero-wait, but answers only as many requests as the stimulus has granted.
    assign bus.imem_ack   = rst_b && bus.imem_req && (ack_total < grant_total);
    assign bus.imem_rdata = mdata(bus.imem_addr);
    always @(posedge clk) if (bus.imem_ack) ack_total <= ack_total + 1;
    always @(negedge clk) if (bus.imem_ack) ack_log.push_back(bus.imem_addr);

    // Monitor: an output register update carrying a non-NOP instruction must match the queue head.
    always @(negedge clk) begin
        if (upd && bus.instruction_1a != 48'h0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got pc=%h insn=%h, required no instruction", bus.pc_1a, bus.instruction_1a);
            end else begin
                e_pc = exp_q.pop_front();
                if (bus.pc_1a !== e_pc || bus.instruction_1a !== mdata(e_pc)) begin
                    n_fail++;
                    $display("FAIL mon_insn: got pc=%h insn=%h, required pc=%h insn=%h",
                             bus.pc_1a, bus.instruction_1a, e_pc, mdata(e_pc));
                end
            end
        end
        upd = rst_b && !bus.stall_2a && !bus.kill_4a;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic grant(input logic [31:0] first_pc, input int n, input bit expect_out);
        grant_total = grant_total + n;
        if (expect_out)
            for (int i = 0; i < n; i++) exp_q.push_back(first_pc + 32'(6 * i));
    endtask

    task automatic chk_acks(input string name, input logic [31:0] addrs[$]);
        chk({name, "_n"}, 64'(ack_log.size()), 64'(addrs.size()));
        for (int i = 0; i < addrs.size() && i < ack_log.size(); i++)
            chk({name, "_addr"}, 64'(ack_log[i]), 64'(addrs[i]));
        ack_log.delete();
    endtask

    initial begin
        rst_b         = 1'b0;
        bus.stall_2a  = 1'b0;
        bus.kill_4a   = 1'b0;
        bus.target_4a = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",  64'(bus.imem_req), 64'd1);
        chk("rst_addr", 64'(bus.imem_addr), 64'h0);
        chk("rst_insn", 64'(bus.instruction_1a), 64'h0);
        chk("rst_pc",   64'(bus.pc_1a), 64'h0);

        // Four zero-wait responses straight after reset.
        drive_edge();
        rst_b = 1'b1;
        grant(32'd0, 4, 1'b1);
        wait_neg(2);
        chk("first_nop_insn", 64'(bus.instruction_1a), 64'h0);
        chk("first_nop_pc",   64'(bus.pc_1a), 64'h0);
        wait_neg(8);
        chk_acks("a_ack", '{32'd0, 32'd6, 32'd12, 32'd18});
        chk("a_drain_insn", 64'(bus.instruction_1a), 64'h0);
        chk("a_drain_pc",   64'(bus.pc_1a), 64'd24);

        // Stall with plenty of grants: only DEPTH responses may be accepted.
        drive_edge();
        bus.stall_2a = 1'b1;
        grant(32'd24, 10, 1'b1);
        wait_neg(10);
        chk_acks("stall_ack", '{32'd24, 32'd30, 32'd36, 32'd42});
        chk("stall_req_off", 64'(bus.imem_req), 64'd0);
        chk("stall_insn",    64'(bus.instruction_1a), 64'h0);
        chk("stall_pc",      64'(bus.pc_1a), 64'd24);
        drive_edge();
        bus.stall_2a = 1'b0;
        wait_neg(20);
        chk_acks("resume_ack", '{32'd48, 32'd54, 32'd60, 32'd66, 32'd72, 32'd78});
        chk("b_drain_pc", 64'(bus.pc_1a), 64'd84);

        // Kill with three entries queued and an ack in the same cycle.
        drive_edge();
        bus.stall_2a = 1'b1;
        grant(32'd84, 3, 1'b0);
        wait_neg(6);
        chk("c_wait_addr", 64'(bus.imem_addr), 64'd102);
        drive_edge();
        bus.kill_4a   = 1'b1;
        bus.target_4a = 32'h101;
        grant(32'd102, 1, 1'b0);
        drive_edge();
        bus.kill_4a  = 1'b0;
        bus.stall_2a = 1'b0;
        @(negedge clk);
        chk("kill_insn", 64'(bus.instruction_1a), 64'h0);
        chk("kill_pc",   64'(bus.pc_1a), 64'h101);
        chk("kill_addr", 64'(bus.imem_addr), 64'h101);
        chk("kill_req",  64'(bus.imem_req), 64'd1);
        drive_edge();
        grant(32'h101, 2, 1'b1);
        wait_neg(8);
        chk_acks("c_ack", '{32'd84, 32'd90, 32'd96, 32'd102, 32'h101, 32'h107});
        chk("c_drain_pc", 64'(bus.pc_1a), 64'h10D);

        // Kill while the request is waiting; the late response is dropped.
        drive_edge();
        bus.kill_4a   = 1'b1;
        bus.target_4a = 32'h200;
        drive_edge();
        bus.kill_4a = 1'b0;
        @(negedge clk);
        chk("drop_addr_held", 64'(bus.imem_addr), 64'h10D);
        chk("drop_req",       64'(bus.imem_req), 64'd1);
        chk("drop_pc",        64'(bus.pc_1a), 64'h200);
        wait_neg(2);
        chk("drop_addr_still", 64'(bus.imem_addr), 64'h10D);
        chk("drop_pc_still",   64'(bus.pc_1a), 64'h200);
        drive_edge();
        grant(32'h10D, 1, 1'b0);
        drive_edge();
        @(negedge clk);
        chk("after_drop_addr", 64'(bus.imem_addr), 64'h200);
        drive_edge();
        grant(32'h200, 1, 1'b1);
        wait_neg(6);
        chk_acks("d_ack", '{32'h10D, 32'h200});

        // Two kills while dropping: the later target wins.
        drive_edge();
        bus.kill_4a   = 1'b1;
        bus.target_4a = 32'h40;
        drive_edge();
        bus.target_4a = 32'h80;
        drive_edge();
        bus.kill_4a = 1'b0;
        @(negedge clk);
        chk("kill2_addr_held", 64'(bus.imem_addr), 64'h206);
        chk("kill2_pc",        64'(bus.pc_1a), 64'h80);
        drive_edge();
        grant(32'h206, 1, 1'b0);
        grant(32'h80, 1, 1'b1);
        wait_neg(6);
        chk_acks("e_ack", '{32'h206, 32'h80});
        chk("e_drain_pc", 64'(bus.pc_1a), 64'h86);

        // Asynchronous reset with two entries queued and a request pending.
        drive_edge();
        bus.stall_2a = 1'b1;
        grant(32'h86, 2, 1'b0);
        wait_neg(4);
        chk("f_pend_req", 64'(bus.imem_req), 64'd1);
        drive_edge();
        rst_b = 1'b0;
        #1;
        chk("arst_req",  64'(bus.imem_req), 64'd1);
        chk("arst_addr", 64'(bus.imem_addr), 64'h0);
        chk("arst_insn", 64'(bus.instruction_1a), 64'h0);
        chk("arst_pc",   64'(bus.pc_1a), 64'h0);
        ack_log.delete();
        drive_edge();
        drive_edge();
        rst_b        = 1'b1;
        bus.stall_2a = 1'b0;
        wait_neg(5);
        chk("arst_empty_insn", 64'(bus.instruction_1a), 64'h0);
        chk("arst_empty_pc",   64'(bus.pc_1a), 64'h0);
        drive_edge();
        grant(32'h0, 1, 1'b1);
        wait_neg(6);
        chk_acks("f_ack", '{32'h0});

        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
